// File: rtl/avl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// avl_pkg : shared Avalon bus widths and the burst-writer state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
package avl_pkg;

  localparam int AVL_ADDR_W         = 32;
  localparam int AVL_DATA_W         = 32;
  localparam int AVL_BURST_W        = 8;
  localparam int AVL_BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    BURST     = 2'd2,
    FINISH    = 2'd3
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/i_avl_bus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i_avl_bus : Avalon-style burst memory bus between a master and the SDRAM slave.
// Rev 1.0
// ---------------------------------------------------------------------------
interface i_avl_bus;
  import avl_pkg::*;

  logic                          write;
  logic                          read;
  logic                          begin_burst_transfer;
  logic [AVL_ADDR_W-1:0]         address;
  logic [AVL_BURST_W-1:0]        burst_count;
  logic [AVL_DATA_W-1:0]         write_data;
  logic [AVL_BYTES_PER_WORD-1:0] byte_en;
  logic                          resp_ready;
  logic                          request_ready;

  modport master (
    output write, read, begin_burst_transfer, address, burst_count,
           write_data, byte_en, resp_ready,
    input  request_ready
  );

  modport slave (
    input  write, read, begin_burst_transfer, address, burst_count,
           write_data, byte_en, resp_ready,
    output request_ready
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock first-word-fall-through FIFO with occupancy count.
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/avl_burst_write_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// avl_burst_write_master : buffers a word stream and writes it as fixed bursts.
// Rev 1.0
// ---------------------------------------------------------------------------
module avl_burst_write_master
  import avl_pkg::*;
#(
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  i_avl_bus.master              avl_m
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_WIDTH-1:0]   BURST_LEN_L = LEN_WIDTH'(BURST_LEN);
  localparam logic [LEN_WIDTH-1:0]   LEN_ONE     = LEN_WIDTH'(1);
  localparam logic [AVL_BURST_W-1:0] BEAT_ONE    = AVL_BURST_W'(1);

  wr_state_t state, state_nxt;

  logic [AVL_ADDR_W-1:0]  addr;
  logic [LEN_WIDTH-1:0]   rem_wr;
  logic [LEN_WIDTH-1:0]   rem_in;
  logic [AVL_BURST_W-1:0] beats_left;
  logic                   first_beat;
  logic [AVL_ADDR_W-1:0]  address_q;
  logic [AVL_BURST_W-1:0] burst_count_q;

  logic [AVL_DATA_W-1:0]  fifo_dout;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic [LEN_WIDTH-1:0]   cur_len;
  logic                   data_ready;
  logic                   push;
  logic                   write;
  logic                   beat_ok;
  logic                   last_beat;
  logic                   launch;
  logic                   accept_start;

  assign cur_len    = (rem_wr < BURST_LEN_L) ? rem_wr : BURST_LEN_L;
  assign data_ready = (LEN_WIDTH'(fifo_count) >= cur_len);
  assign in_ready   = (state != IDLE) && !fifo_full && (rem_in != '0);
  assign push       = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (AVL_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_data),
    .pop   (beat_ok),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    launch       = 1'b0;
    write        = (state == BURST);
    busy         = (state == WAIT_DATA) || (state == BURST);
    done         = (state == FINISH);
    beat_ok      = write && avl_m.request_ready;
    last_beat    = beat_ok && (beats_left == BEAT_ONE);
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = (length == '0) ? FINISH : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_ready) begin
          launch    = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (last_beat) state_nxt = (rem_wr == LEN_ONE) ? FINISH : WAIT_DATA;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      rem_wr        <= '0;
      rem_in        <= '0;
      beats_left    <= '0;
      first_beat    <= 1'b0;
      address_q     <= '0;
      burst_count_q <= '0;
    end else begin
      if (accept_start) begin
        addr   <= base_addr;
        rem_wr <= length;
        rem_in <= length;
      end
      if (push) rem_in <= rem_in - LEN_ONE;
      if (launch) begin
        address_q     <= addr;
        burst_count_q <= AVL_BURST_W'(cur_len);
        beats_left    <= AVL_BURST_W'(cur_len);
        first_beat    <= 1'b1;
      end
      if (beat_ok) begin
        rem_wr     <= rem_wr - LEN_ONE;
        beats_left <= beats_left - BEAT_ONE;
        first_beat <= 1'b0;
      end
      // Address advance wraps freely at 2^32.
      if (last_beat) addr <= addr + AVL_ADDR_W'({burst_count_q, 2'b00});
    end
  end

  assign avl_m.write                = write;
  assign avl_m.read                 = 1'b0;
  assign avl_m.begin_burst_transfer = write && first_beat;
  assign avl_m.address              = address_q;
  assign avl_m.burst_count          = burst_count_q;
  assign avl_m.write_data           = write ? fifo_dout : '0;
  assign avl_m.byte_en              = '1;
  assign avl_m.resp_ready           = 1'b1;

endmodule
`default_nettype wire

// File: doc/avl_burst_write_master.md
Name: avl_burst_write_master

Overview:
- Stream-to-memory stage that sits directly upstream of the SDRAM controller's Avalon-style slave port, driving an i_avl_bus master modport.
- Accepts a 32-bit word stream, for example packed camera pixels from the OV5640 capture path, and buffers it in an internal FIFO.
- Writes the buffered data to memory as fixed-length bursts starting at a programmed base address.
- One transfer covers one frame (LENGTH words) and completes with a done pulse.

Parameters:
- BURST_LEN, 64, maximum words per burst (1..255; fits the 8-bit burst_count).
- FIFO_DEPTH, 256, internal FIFO depth in words; power of two, must be >= BURST_LEN.
- LEN_WIDTH, 24, width of the word-count inputs and counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a transfer when idle.
- base_addr  in  32  byte address of the first word; sampled on start; must be 4-byte aligned.
- length  in  LEN_WIDTH  total words to write; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when the last beat is accepted.
- in_data  in  32  stream data.
- in_valid  in  1  stream data valid.
- in_ready  out  1  stream ready; a word transfers when in_valid && in_ready.
- avl_m  i_avl_bus.master  -  memory bus master port.

Behaviour:
- Reset values:
  - busy=0, done=0, in_ready=0.
  - On avl_m: write=0, read=0, begin_burst_transfer=0, address=0, burst_count=0, write_data=0.
  - byte_en=4'hF and resp_ready=1 at all times; read is tied to 0.
  - FIFO emptied, state IDLE.
- States: IDLE, WAIT_DATA, BURST, FINISH.
- IDLE:
  - On start, latch addr=base_addr, rem_wr=length, rem_in=length.
  - If length==0, go to FINISH; otherwise go to WAIT_DATA.
  - start while not IDLE is ignored.
- Input side:
  - in_ready = (state != IDLE) && fifo_not_full && (rem_in != 0).
  - rem_in decrements on each accepted word.
  - Words beyond length are never accepted.
- WAIT_DATA:
  - cur_len = min(BURST_LEN, rem_wr).
  - When fifo_count >= cur_len, register burst_count=cur_len and address=addr, then enter BURST.
- BURST:
  - write=1, write_data = FIFO head (first-word-fall-through), begin_burst_transfer=1 until the first beat is accepted.
  - A beat is accepted when write && request_ready. Each accepted beat pops the FIFO and decrements rem_wr and the beat counter.
  - address and burst_count are held constant for the whole burst.
  - When request_ready=0, all master outputs are held stable.
  - After the last beat of a burst: addr += cur_len*4, modulo 2^32 (wrap allowed, no error).
  - Next state is WAIT_DATA if rem_wr != 0, else FINISH.
  - Bursts are back-to-back with at least one idle cycle (WAIT_DATA) between them.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- Boundary cases:
  - Last partial burst: burst_count = remainder, e.g. length=100, BURST_LEN=64 gives bursts of 64 and 36.
  - FIFO full: in_ready=0 and no data is lost.
  - Simultaneous push and pop in one cycle: fifo_count unchanged.
  - rst mid-burst: all outputs go to reset values immediately (asynchronous); the partially written burst is abandoned and the slave must tolerate this.
- Latency:
  - start in cycle N → busy=1 at N+1.
  - Once the FIFO holds cur_len words in cycle M, write is asserted at M+1.

Decomposition:
- Package avl_pkg holds:
  - AVL_ADDR_W=32, AVL_DATA_W=32, AVL_BURST_W=8, AVL_BYTES_PER_WORD=4.
  - The state enum typedef.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - First-word-fall-through, with count, full and empty outputs.
  - Simultaneous push and pop allowed when full or empty as appropriate.

Test Plan:
- Single full burst:
  - Stimulus: base_addr=0x1000, length=64, stream 0..63 with no stalls.
  - Required: one burst, address=0x1000, burst_count=64; begin_burst_transfer only on beat 0; write_data 0..63 in order; done once.
- Partial last burst:
  - Stimulus: length=100.
  - Required: bursts at 0x1000/64 and 0x1100/36; rem=0; done after beat 36.
- Slave backpressure:
  - Stimulus: request_ready low for 3 cycles mid-burst, and random thereafter.
  - Required: outputs stable while stalled; no beat lost or duplicated; data matches the scoreboard.
- Source stalls and FIFO full:
  - Stimulus: request_ready=0 until the FIFO holds 256 words.
  - Required: in_ready drops at 256 words; streaming resumes once the FIFO drains.
- length=0 and start while busy:
  - Stimulus: start with length=0; separately, a second start issued mid-transfer.
  - Required: length=0 gives done at the next cycle with no write. The second start is ignored, and the original transfer completes correctly.
- Reset mid-burst:
  - Stimulus: assert rst during beat 10.
  - Required: write=0 and busy=0 immediately. A new start with length=8 then writes 8 fresh words correctly.
